// File: rtl/snake_draw_pkg.sv
// Shared definitions for the tile drawing path: FSM state encoding, default
// tile geometry and the colour palette used by the painting controllers.
package snake_draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } draw_state_e;

    localparam int TILE      = 4;
    localparam int TILE_LOG2 = $clog2(TILE);
    localparam int PIX_W     = 2 * TILE_LOG2;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

endpackage

// File: rtl/draw_req_picker.sv
// Combinational winner selection among the tile draw requesters.
// Build option: ROUND_ROBIN_EN selects a rotating search start at rr_ptr;
// without it the lowest asserted index wins and no pointer input exists.
module draw_req_picker
    import snake_draw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]   rr_ptr,
`endif
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

`ifdef ROUND_ROBIN_EN
    // First asserted request found walking upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        int cand;
        cand  = 0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end
`else
    // Lowest asserted request index wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/vga_tile_draw_arbiter.sv
// Shares the VGA adapter write port between the tile painters (snake, food,
// clear, score). One requester is granted, its origin and colour latched, and
// TILE*TILE plot cycles are emitted row-major, followed by a done pulse.
// Build option: ROUND_ROBIN_EN enables round-robin arbitration (default is
// fixed priority, lowest index first).
module vga_tile_draw_arbiter
    import snake_draw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int C_W     = 3,
    parameter int TILE    = snake_draw_pkg::TILE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot
);

    localparam int T_LOG2 = $clog2(TILE);
    localparam int PW     = 2 * T_LOG2;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(TILE * TILE - 1);

    draw_state_e          state_r;
    logic [PW-1:0]        pix_cnt_r;
    logic [IDX_W-1:0]     win_r;
    logic [X_W-1:0]       ox_r;
    logic [Y_W-1:0]       oy_r;
    logic [C_W-1:0]       oc_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   done_r;
    logic                 busy_r;
    logic [X_W-1:0]       vx_r;
    logic [Y_W-1:0]       vy_r;
    logic [C_W-1:0]       vc_r;
    logic                 plot_r;

    logic                 pick_valid_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [X_W-1:0]       sel_x_s;
    logic [Y_W-1:0]       sel_y_s;
    logic [C_W-1:0]       sel_c_s;
    logic [PW-1:0]        pix_next_s;
    logic [X_W-1:0]       draw_x_s;
    logic [Y_W-1:0]       draw_y_s;

    // One-hot vector for a requester index
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_r;

    // Advance the search start to just past each new winner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else if (state_r == IDLE && pick_valid_s) begin
            if (pick_idx_s == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= pick_idx_s + 1'b1;
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    draw_req_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
`ifdef ROUND_ROBIN_EN
        .rr_ptr (rr_ptr_r),
`endif
        .valid  (pick_valid_s),
        .idx    (pick_idx_s)
    );

    // Winner's request fields and the next pixel position inside the tile
    always_comb begin
        sel_x_s    = req_x[pick_idx_s*X_W +: X_W];
        sel_y_s    = req_y[pick_idx_s*Y_W +: Y_W];
        sel_c_s    = req_colour[pick_idx_s*C_W +: C_W];
        pix_next_s = pix_cnt_r + 1'b1;
        draw_x_s   = ox_r + X_W'(pix_next_s[T_LOG2-1:0]);
        draw_y_s   = oy_r + Y_W'(pix_next_s[PW-1:T_LOG2]);
    end

    // Arbitration FSM with request latch, pixel counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            pix_cnt_r <= '0;
            win_r     <= '0;
            ox_r      <= '0;
            oy_r      <= '0;
            oc_r      <= '0;
            grant_r   <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            vx_r      <= '0;
            vy_r      <= '0;
            vc_r      <= '0;
            plot_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= '0;
                    plot_r    <= 1'b0;
                    vx_r      <= '0;
                    vy_r      <= '0;
                    vc_r      <= '0;
                    pix_cnt_r <= '0;
                    if (pick_valid_s) begin
                        state_r <= GRANT;
                        win_r   <= pick_idx_s;
                        ox_r    <= sel_x_s;
                        oy_r    <= sel_y_s;
                        oc_r    <= sel_c_s;
                        grant_r <= idx_onehot(pick_idx_s);
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    state_r   <= DRAW;
                    pix_cnt_r <= '0;
                    plot_r    <= 1'b1;
                    vx_r      <= ox_r;
                    vy_r      <= oy_r;
                    vc_r      <= oc_r;
                end
                DRAW: begin
                    if (pix_cnt_r == PIX_LAST) begin
                        state_r   <= DONE;
                        pix_cnt_r <= '0;
                        plot_r    <= 1'b0;
                        vx_r      <= '0;
                        vy_r      <= '0;
                        vc_r      <= '0;
                        grant_r   <= '0;
                        done_r    <= idx_onehot(win_r);
                    end else begin
                        state_r   <= DRAW;
                        pix_cnt_r <= pix_next_s;
                        vx_r      <= draw_x_s;
                        vy_r      <= draw_y_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    pix_cnt_r <= '0;
                    grant_r   <= '0;
                    done_r    <= '0;
                    busy_r    <= 1'b0;
                    plot_r    <= 1'b0;
                    vx_r      <= '0;
                    vy_r      <= '0;
                    vc_r      <= '0;
                end
            endcase
        end
    end

    assign grant      = grant_r;
    assign done       = done_r;
    assign busy       = busy_r;
    assign vga_x      = vx_r;
    assign vga_y      = vy_r;
    assign vga_colour = vc_r;
    assign vga_plot   = plot_r;

endmodule

// File: tb/tb_vga_tile_draw_arbiter.sv
// Scoreboard bench for vga_tile_draw_arbiter: stimulus pushes expected grants,
// pixels and done pulses; an independent monitor pops and compares them.
module tb_vga_tile_draw_arbiter;
    import snake_draw_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NUM_REQ-1:0]     req = '0;
    logic [NUM_REQ*X_W-1:0] req_x = '0;
    logic [NUM_REQ*Y_W-1:0] req_y = '0;
    logic [NUM_REQ*C_W-1:0] req_colour = '0;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic [X_W-1:0]         vga_x;
    logic [Y_W-1:0]         vga_y;
    logic [C_W-1:0]         vga_colour;
    logic                   vga_plot;

    vga_tile_draw_arbiter #(
        .NUM_REQ (NUM_REQ), .X_W (X_W), .Y_W (Y_W), .C_W (C_W), .TILE (4)
    ) dut (
        .clk (clk), .rst (rst), .req (req), .req_x (req_x), .req_y (req_y),
        .req_colour (req_colour), .grant (grant), .done (done), .busy (busy),
        .vga_x (vga_x), .vga_y (vga_y), .vga_colour (vga_colour), .vga_plot (vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_pix[$];
    int   exp_grant[$];
    int   exp_done[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the expected response of one tile: grant, npix pixels, optional done
    task automatic expect_tile(input int idx, input int x, input int y, input int c,
                               input int npix, input bit with_done);
        pix_t e;
        exp_grant.push_back(idx);
        for (int p = 0; p < npix; p++) begin
            e.x = 8'((x + p % 4) % 256);
            e.y = 7'((y + p / 4) % 128);
            e.c = 3'(c);
            exp_pix.push_back(e);
        end
        if (with_done) exp_done.push_back(idx);
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*X_W +: X_W]      = 8'(x);
        req_y[i*Y_W +: Y_W]      = 7'(y);
        req_colour[i*C_W +: C_W] = 3'(c);
        req[i]                   = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int idx, input bit drop);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!done[idx] && k < 200);
        if (!done[idx]) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout_done%0d: got no done expected done within 200 cycles", idx);
        end else if (drop) begin
            req[idx] = 1'b0;
        end
    endtask

    // Monitor: compares every plot, grant rise and done pulse against the queues
    initial begin : monitor
        pix_t e;
        int   gi;
        logic [NUM_REQ-1:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (vga_plot) begin
                if (exp_pix.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL plot_unexpected: got plot at (%0d,%0d) expected none", vga_x, vga_y);
                end else begin
                    e = exp_pix.pop_front();
                    check("pix_x", 32'(vga_x), 32'(e.x));
                    check("pix_y", 32'(vga_y), 32'(e.y));
                    check("pix_colour", 32'(vga_colour), 32'(e.c));
                end
            end
            if (grant != '0) check("grant_onehot", $countones(grant), 1);
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL grant_unexpected: got %b expected none", grant);
                end else begin
                    gi = exp_grant.pop_front();
                    check("grant_idx", 32'(grant), 32'(1 << gi));
                end
            end
            if (done != '0) begin
                if (exp_done.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL done_unexpected: got %b expected none", done);
                end else begin
                    gi = exp_done.pop_front();
                    check("done_idx", 32'(done), 32'(1 << gi));
                end
            end
            prev_grant = grant;
        end
    end

    initial begin : stimulus
        // Reset state
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        do_reset();
        repeat (3) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_plot", 32'(vga_plot), 32'd0);
        check("idle_x", 32'(vga_x), 32'd0);

        // 1: single request
        expect_tile(0, 8, 12, 7, 16, 1'b1);
        set_req(0, 8, 12, WHITE);
        tick();
        check("t1_grant_first", 32'(grant), 32'd1);
        check("t1_plot_in_grant", 32'(vga_plot), 32'd0);
        tick();
        check("t1_first_x", 32'(vga_x), 32'd8);
        check("t1_first_y", 32'(vga_y), 32'd12);
        wait_done(0, 1'b1);
        check("t1_busy_in_done", 32'(busy), 32'd1);
        tick();
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: simultaneous req[2] and req[0]
        do_reset();
        expect_tile(0, 0, 0, 4, 16, 1'b1);
        expect_tile(2, 16, 4, 2, 16, 1'b1);
        set_req(0, 0, 0, RED);
        set_req(2, 16, 4, GREEN);
        wait_done(0, 1'b1);
        wait_done(2, 1'b1);

        // 3: all four requesters
        do_reset();
`ifdef ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) expect_tile(i, 40 + 4 * i, 8 * i, i + 1, 16, 1'b1);
        expect_tile(0, 40, 0, 1, 16, 1'b1);
        for (int i = 0; i < 4; i++) set_req(i, 40 + 4 * i, 8 * i, i + 1);
        for (int i = 0; i < 4; i++) wait_done(i, 1'b0);
        wait_done(0, 1'b0);
        req = '0;
`else
        for (int i = 0; i < 4; i++) expect_tile(i, 40 + 4 * i, 8 * i, i + 1, 16, 1'b1);
        for (int i = 0; i < 4; i++) set_req(i, 40 + 4 * i, 8 * i, i + 1);
        for (int i = 0; i < 4; i++) wait_done(i, 1'b1);
`endif

        // 4: coordinate wrap-around
        do_reset();
        expect_tile(3, 254, 126, 7, 16, 1'b1);
        set_req(3, 254, 126, WHITE);
        tick();
        tick();
        check("t4_x0", 32'(vga_x), 32'd254);
        check("t4_y0", 32'(vga_y), 32'd126);
        tick();
        check("t4_x1", 32'(vga_x), 32'd255);
        tick();
        check("t4_x2", 32'(vga_x), 32'd0);
        tick();
        check("t4_x3", 32'(vga_x), 32'd1);
        tick();
        check("t4_row1_y", 32'(vga_y), 32'd127);
        repeat (4) tick();
        check("t4_row2_y", 32'(vga_y), 32'd0);
        repeat (4) tick();
        check("t4_row3_y", 32'(vga_y), 32'd1);
        wait_done(3, 1'b1);

        // 5: reset at pixel 5 aborts the tile, held request restarts at pixel 0
        do_reset();
        expect_tile(0, 20, 30, 4, 6, 1'b0);
        expect_tile(0, 20, 30, 4, 16, 1'b1);
        set_req(0, 20, 30, RED);
        begin
            int k;
            k = 0;
            while (!(vga_plot && vga_x == 8'd21 && vga_y == 7'd31) && k < 50) begin
                tick();
                k++;
            end
        end
        check("t5_reached_pix5", 32'(vga_x), 32'd21);
        rst = 1'b0;
        #1;
        check("t5_plot_rst", 32'(vga_plot), 32'd0);
        check("t5_grant_rst", 32'(grant), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        tick();
        check("t5_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        wait_done(0, 1'b1);

        // 6: drop request and change origin during the draw
        do_reset();
        expect_tile(0, 40, 50, 2, 16, 1'b1);
        set_req(0, 40, 50, GREEN);
        begin
            int k;
            k = 0;
            while (!(vga_plot && vga_x == 8'd43) && k < 50) begin
                tick();
                k++;
            end
        end
        check("t6_reached_pix3", 32'(vga_x), 32'd43);
        req[0] = 1'b0;
        req_x[0 +: X_W] = 8'd100;
        wait_done(0, 1'b0);

        repeat (6) tick();
        check("left_pixels", exp_pix.size(), 0);
        check("left_grants", exp_grant.size(), 0);
        check("left_dones", exp_done.size(), 0);
        check("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
